jmp_seq: RTL and testbench

JMP_SEQ -- requirements
Module: jmp_seq

---
 rtl/jmp_seq_if.sv | 14 +
 rtl/jmp_seq.sv | 178 +++++++++++++++++
 tb/tb_jmp_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/jmp_seq_if.sv
// rtl/jmp_seq_if.sv - operand byte fetch bus between jmp_seq and memory
// Signals:
//   mem_req   sequencer -> memory  operand byte fetch request
//   mem_ack   memory -> sequencer  operand byte valid on mem_data this cycle
//   mem_data  memory -> sequencer  operand byte
// Modports: master (sequencer side), slave (memory side).
interface jmp_seq_if;
  logic       mem_req;
  logic       mem_ack;
  logic [7:0] mem_data;

  modport master (output mem_req, input mem_ack, input mem_data);
  modport slave  (input mem_req, output mem_ack, output mem_data);
endinterface

// File: rtl/jmp_seq.sv
// rtl/jmp_seq.sv - jump instruction operand fetch and execute sequencer
// Optional feature macro: JMP_SHORT_EN (one-byte relative form with sign extension).
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   start, cins   jump opcode decoded / opcode byte, accepted only in IDLE
//   short_op      one-byte relative form request (JMP_SHORT_EN builds only)
//   mem           operand fetch bus (jmp_seq_if.master)
//   dbus          data to jump unit databus
//   highbits_we   jump unit high-byte write strobe
//   cins_q        latched opcode to jump unit
//   jmp_oe, pcoe  jump unit evaluate strobe / its "taken" result
//   pc_inc        advance PC by one
//   pc_load       load PC from jump unit
//   busy, done    not idle / one-cycle end-of-sequence pulse
//   err           sticky fetch timeout flag
module jmp_seq #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cins,
  input  logic        short_op,
  jmp_seq_if.master   mem,
  output logic [7:0]  dbus,
  output logic        highbits_we,
  output logic [7:0]  cins_q,
  output logic        jmp_oe,
  input  logic        pcoe,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_HI,
    S_FETCH_LO,
`ifdef JMP_SHORT_EN
    S_SEXT,
`endif
    S_EXEC
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cins_q;
  logic [7:0] r_lo_q;
  logic [7:0] r_wait;
  logic       r_err;
  logic       w_accept;
  logic       w_abort;
  logic       w_lo_we;
  logic       w_fetch;
  logic       w_mem_req;

`ifdef JMP_SHORT_EN
  logic       r_short;
`else
  logic       w_unused_short;
  assign w_unused_short = short_op;
`endif

  assign w_fetch     = (r_state == S_FETCH_HI) || (r_state == S_FETCH_LO);
  assign mem.mem_req = w_mem_req;
  assign cins_q      = r_cins_q;
  assign err         = r_err;
  assign busy        = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    w_lo_we     = 1'b0;
    w_mem_req   = 1'b0;
    dbus        = 8'h00;
    highbits_we = 1'b0;
    jmp_oe      = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FETCH_HI;
`ifdef JMP_SHORT_EN
          if (short_op) w_state_nxt = S_FETCH_LO;
`endif
        end
      end
      S_FETCH_HI: begin
        // Abort cycle drops mem_req; a late ack here is not consumed.
        if (r_wait == LP_TIMEOUT) begin
          w_abort     = 1'b1;
          done        = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_mem_req = 1'b1;
          if (mem.mem_ack) begin
            dbus        = mem.mem_data;
            highbits_we = 1'b1;
            pc_inc      = 1'b1;
            w_state_nxt = S_FETCH_LO;
          end
        end
      end
      S_FETCH_LO: begin
        if (r_wait == LP_TIMEOUT) begin
          w_abort     = 1'b1;
          done        = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_mem_req = 1'b1;
          if (mem.mem_ack) begin
            w_lo_we     = 1'b1;
            pc_inc      = 1'b1;
            w_state_nxt = S_EXEC;
`ifdef JMP_SHORT_EN
            if (r_short) w_state_nxt = S_SEXT;
`endif
          end
        end
      end
`ifdef JMP_SHORT_EN
      S_SEXT: begin
        dbus        = {8{r_lo_q[7]}};
        highbits_we = 1'b1;
        w_state_nxt = S_EXEC;
      end
`endif
      S_EXEC: begin
        // Both pc_inc pulses have landed by now, so pcout is relative to
        // the address after the operand bytes.
        dbus        = r_lo_q;
        jmp_oe      = 1'b1;
        pc_load     = pcoe;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cins_q <= 8'h00;
      r_lo_q   <= 8'h00;
      r_wait   <= 8'h00;
      r_err    <= 1'b0;
`ifdef JMP_SHORT_EN
      r_short  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cins_q <= cins;
`ifdef JMP_SHORT_EN
        r_short  <= short_op;
`endif
      end
      if (w_lo_we) r_lo_q <= mem.mem_data;
      if (w_accept)     r_err <= 1'b0;
      else if (w_abort) r_err <= 1'b1;
      // Counter measures consecutive un-acked cycles within one fetch.
      if ((w_state_nxt != r_state) || (w_fetch && mem.mem_ack))
        r_wait <= 8'h00;
      else if (w_fetch)
        r_wait <= r_wait + 8'd1;
    end
  end

endmodule

// File: tb/tb_jmp_seq.sv
// tb/tb_jmp_seq.sv - directed self-checking bench for jmp_seq
module tb_jmp_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] cins;
  logic       short_op;
  logic [7:0] dbus;
  logic       highbits_we;
  logic [7:0] cins_q;
  logic       jmp_oe;
  logic       pcoe;
  logic       pc_inc;
  logic       pc_load;
  logic       busy;
  logic       done;
  logic       err;
  logic       tb_taken;
  logic [7:0] w_strb;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_pcinc  = 0;
  int exp_done = 0;

  jmp_seq_if bus ();

  jmp_seq #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cins        (cins),
    .short_op    (short_op),
    .mem         (bus.master),
    .dbus        (dbus),
    .highbits_we (highbits_we),
    .cins_q      (cins_q),
    .jmp_oe      (jmp_oe),
    .pcoe        (pcoe),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // Jump unit model: taken result follows the evaluate strobe.
  assign pcoe   = tb_taken & jmp_oe;
  // Strobe vector: {mem_req, highbits_we, jmp_oe, pc_inc, pc_load, busy, done, err}
  assign w_strb = {bus.mem_req, highbits_we, jmp_oe, pc_inc, pc_load, busy, done, err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (done)   n_done++;
    if (pc_inc) n_pcinc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, check outputs at the falling edge.
  task automatic cyc(input string tag, input logic st, input logic [7:0] ci, input logic sh,
                     input logic ack, input logic [7:0] md,
                     input logic [7:0] exp_strb, input logic [7:0] exp_dbus);
    start        = st;
    cins         = ci;
    short_op     = sh;
    bus.mem_ack  = ack;
    bus.mem_data = md;
    @(negedge clk);
    check({tag, " strb"}, 32'(w_strb), 32'(exp_strb));
    check({tag, " dbus"}, 32'(dbus), 32'(exp_dbus));
    @(posedge clk);
    #1;
    start       = 1'b0;
    short_op    = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  task automatic long_jump(input string tag, input logic [7:0] ci, input logic [7:0] hi,
                           input logic [7:0] lo, input logic taken, input logic sh,
                           input logic [7:0] s0);
    tb_taken = taken;
    cyc({tag, " start"}, 1'b1, ci, sh, 1'b0, 8'h00, s0, 8'h00);
    cyc({tag, " hi"}, 1'b0, 8'h00, 1'b0, 1'b1, hi, 8'hD4, hi);
    cyc({tag, " lo"}, 1'b0, 8'h00, 1'b0, 1'b1, lo, 8'h94, 8'h00);
    cyc({tag, " exec"}, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, taken ? 8'h2E : 8'h26, lo);
    cyc({tag, " idle"}, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check({tag, " cins_q"}, 32'(cins_q), 32'(ci));
    exp_done++;
  endtask

  initial begin
    int p0;
    int d0;
    rst          = 1'b0;
    start        = 1'b0;
    cins         = 8'h00;
    short_op     = 1'b0;
    tb_taken     = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.mem_data = 8'h00;
    #2;
    check("reset strb", 32'(w_strb), 32'h0);
    check("reset cins_q", 32'(cins_q), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    long_jump("long taken", 8'h01, 8'h12, 8'h34, 1'b1, 1'b0, 8'h00);

    p0 = n_pcinc;
    long_jump("not taken", 8'h02, 8'h12, 8'h34, 1'b0, 1'b0, 8'h00);
    check("not taken pc_inc count", 32'(n_pcinc - p0), 32'd2);

`ifdef JMP_SHORT_EN
    tb_taken = 1'b1;
    cyc("short start", 1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    cyc("short lo", 1'b0, 8'h00, 1'b0, 1'b1, 8'hF0, 8'h94, 8'h00);
    cyc("short sext", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h44, 8'hFF);
    cyc("short exec", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h2E, 8'hF0);
    cyc("short idle", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    exp_done++;
`else
    long_jump("short as long", 8'h03, 8'hAB, 8'hF0, 1'b1, 1'b1, 8'h00);
`endif

    // Timeout after 4 un-acked FETCH_HI cycles.
    cyc("tmo start", 1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++)
      cyc("tmo wait", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h84, 8'h00);
    cyc("tmo abort", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h06, 8'h00);
    exp_done++;
    cyc("tmo idle ack ignored", 1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 8'h01, 8'h00);
    long_jump("tmo restart", 8'h05, 8'h12, 8'h34, 1'b1, 1'b0, 8'h01);

    // Three waits in each fetch stays below the limit.
    tb_taken = 1'b1;
    cyc("wait3 start", 1'b1, 8'h06, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++)
      cyc("wait3 hi wait", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h84, 8'h00);
    cyc("wait3 hi", 1'b0, 8'h00, 1'b0, 1'b1, 8'h12, 8'hD4, 8'h12);
    for (int i = 0; i < 3; i++)
      cyc("wait3 lo wait", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h84, 8'h00);
    cyc("wait3 lo", 1'b0, 8'h00, 1'b0, 1'b1, 8'h34, 8'h94, 8'h00);
    cyc("wait3 exec", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h2E, 8'h34);
    cyc("wait3 idle", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    exp_done++;

    // Reset during FETCH_LO after two wait states.
    cyc("rst start", 1'b1, 8'h07, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    cyc("rst hi", 1'b0, 8'h00, 1'b0, 1'b1, 8'h12, 8'hD4, 8'h12);
    cyc("rst lo wait", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h84, 8'h00);
    cyc("rst lo wait", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h84, 8'h00);
    d0 = n_done;
    rst = 1'b0;
    #1;
    check("async rst strb", 32'(w_strb), 32'h0);
    check("async rst dbus", 32'(dbus), 32'h0);
    check("async rst cins_q", 32'(cins_q), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst no done", 32'(n_done - d0), 32'd0);
    long_jump("after rst", 8'h08, 8'h12, 8'h34, 1'b1, 1'b0, 8'h00);

    // Starts while busy are ignored.
    tb_taken = 1'b1;
    cyc("busy start", 1'b1, 8'h09, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    cyc("busy hi start", 1'b1, 8'h0A, 1'b0, 1'b1, 8'h12, 8'hD4, 8'h12);
    cyc("busy lo", 1'b0, 8'h00, 1'b0, 1'b1, 8'h34, 8'h94, 8'h00);
    cyc("busy exec start", 1'b1, 8'h0B, 1'b0, 1'b0, 8'h00, 8'h2E, 8'h34);
    cyc("busy idle", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("busy cins_q", 32'(cins_q), 32'h09);
    exp_done++;

    check("done count", 32'(n_done), 32'(exp_done));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
